// File: rtl/ce_pkg.sv
// ce_pkg: shared helpers for the CE post-processing block.
//   ce_dw   - width of a CE result: N + M + EXT
//   clog2   - ceiling log2 for elaboration-time sizing
//   sat_hi  - upper clamp bound for an N-bit output (unsigned when relu != 0)
//   sat_lo  - lower clamp bound for an N-bit output (zero when relu != 0)
package ce_pkg;

  function automatic int ce_dw(input int n, input int m, input int ext);
    return n + m + ext;
  endfunction

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int sat_hi(input int n, input int relu);
    return (relu != 0) ? ((1 << n) - 1) : ((1 << (n - 1)) - 1);
  endfunction

  function automatic int sat_lo(input int n, input int relu);
    return (relu != 0) ? 0 : -(1 << (n - 1));
  endfunction

endpackage

// File: rtl/ce_post_fifo.sv
// ce_post_fifo: first-word fall-through FIFO for post-processed results.
// Pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; the extra MSB
// distinguishes full from empty.
// Ports:
//   clk, rst        clock, async active-low reset (clears pointers)
//   wr_en_i         write request
//   wr_data_i       write data
//   rd_en_i         read request (ignored when empty)
//   rd_data_o       head data, zero when empty
//   valid_o         FIFO non-empty
//   almost_full_o   occupancy >= DEPTH-2
//   wr_ok_o         write accepted this cycle
//   drop_o          write refused: full with no read in the same cycle
module ce_post_fifo
  import ce_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             valid_o,
  output logic             almost_full_o,
  output logic             wr_ok_o,
  output logic             drop_o
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [AW:0]      level;
  logic             full;
  logic             empty;
  logic             rd_ok;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A read frees the slot the simultaneous write lands in when full.
  assign rd_ok   = rd_en_i && !empty;
  assign wr_ok_o = wr_en_i && (!full || rd_ok);
  assign drop_o  = wr_en_i && full && !rd_ok;

  assign level         = wr_ptr_q - rd_ptr_q;
  assign almost_full_o = (level >= (AW+1)'(DEPTH - 2));
  assign valid_o       = !empty;
  assign rd_data_o     = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_ok_o) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_ok_o) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_ok)   rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/ce_post.sv
// ce_post: CE result post-processing. Adds a per-channel bias, shifts
// right arithmetically by SR, saturates to N bits (ReLU or signed) and
// buffers the results in an output FIFO with a frame counter.
// Optional build macro: CE_POST_ROUND_EN selects round-half-up before the
// shift; without it the shift truncates (floor). Latency is the same.
// Ports:
//   clk, rst      clock, async active-low reset
//   d_in          CE result, two's complement, DW bits
//   en_in         d_in/bias valid strobe, one result per cycle
//   bias          per-channel bias, two's complement, BW bits
//   d_out         FIFO head data, N bits
//   out_valid     FIFO non-empty
//   out_ready     consumer accepts d_out when out_valid is high
//   almost_full   FIFO occupancy >= DEPTH-2
//   sat           one-cycle pulse when a clipped result enters the FIFO
//   overflow      sticky: a result was lost to a full FIFO
//   frame_done    one-cycle pulse on the FRAME_LEN-th accepted write
module ce_post
  import ce_pkg::*;
#(
  parameter int N         = 2,
  parameter int M         = 2,
  parameter int EXT       = 15,
  parameter int SR        = 2,
  parameter int RELU      = 1,
  parameter int BW        = 8,
  parameter int DEPTH     = 4,
  parameter int FRAME_LEN = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ce_dw(N, M, EXT)-1:0]  d_in,
  input  logic                         en_in,
  input  logic [BW-1:0]                bias,
  output logic [N-1:0]                 d_out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         almost_full,
  output logic                         sat,
  output logic                         overflow,
  output logic                         frame_done
);

  localparam int DW  = ce_dw(N, M, EXT);
  localparam int FCW = clog2(FRAME_LEN + 1);
  localparam logic signed [DW+1:0] SAT_HI = (DW+2)'(sat_hi(N, RELU));
  localparam logic signed [DW+1:0] SAT_LO = (DW+2)'(sat_lo(N, RELU));

  // Stage 1: biased sum at DW+1 bits
  logic signed [DW:0] v1_d;
  logic signed [DW:0] v1_q;
  logic               v1_valid_q;

  assign v1_d = $signed({d_in[DW-1], d_in}) +
                $signed({{(DW + 1 - BW){bias[BW-1]}}, bias});

  // Stage 2: optional rounding, shift, clamp. One extra bit keeps the
  // rounding add from wrapping.
  logic signed [DW+1:0] v_ext;
  logic signed [DW+1:0] shifted;
  logic [N-1:0]         s2_data_d;
  logic                 s2_sat_d;
  logic [N-1:0]         s2_data_q;
  logic                 s2_sat_q;
  logic                 s2_valid_q;

`ifdef CE_POST_ROUND_EN
  localparam int RND_SH = (SR > 0) ? SR - 1 : 0;
  localparam logic signed [DW+1:0] RND = (SR > 0) ? ((DW+2)'(1) << RND_SH) : '0;
  assign v_ext = {v1_q[DW], v1_q} + RND;
`else
  assign v_ext = {v1_q[DW], v1_q};
`endif

  assign shifted = v_ext >>> SR;

  // A ReLU clamp of a negative value is not a saturation event.
  always_comb begin
    s2_data_d = shifted[N-1:0];
    s2_sat_d  = 1'b0;
    if (shifted > SAT_HI) begin
      s2_data_d = SAT_HI[N-1:0];
      s2_sat_d  = 1'b1;
    end else if (shifted < SAT_LO) begin
      s2_data_d = SAT_LO[N-1:0];
      s2_sat_d  = (RELU == 0);
    end
  end

  logic           fifo_wr_ok;
  logic           fifo_drop;
  logic [FCW-1:0] frame_cnt_q;
  logic           sat_q;
  logic           overflow_q;
  logic           frame_done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q         <= '0;
      v1_valid_q   <= 1'b0;
      s2_data_q    <= '0;
      s2_sat_q     <= 1'b0;
      s2_valid_q   <= 1'b0;
      frame_cnt_q  <= '0;
      sat_q        <= 1'b0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      v1_valid_q <= en_in;
      if (en_in) v1_q <= v1_d;
      s2_valid_q <= v1_valid_q;
      if (v1_valid_q) begin
        s2_data_q <= s2_data_d;
        s2_sat_q  <= s2_sat_d;
      end
      sat_q        <= fifo_wr_ok && s2_sat_q;
      overflow_q   <= overflow_q || fifo_drop;
      frame_done_q <= 1'b0;
      if (fifo_wr_ok) begin
        if (frame_cnt_q == FCW'(FRAME_LEN - 1)) begin
          frame_cnt_q  <= '0;
          frame_done_q <= 1'b1;
        end else begin
          frame_cnt_q <= frame_cnt_q + 1'b1;
        end
      end
    end
  end

  ce_post_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (N)
  ) u_fifo (
    .clk           (clk),
    .rst           (rst),
    .wr_en_i       (s2_valid_q),
    .wr_data_i     (s2_data_q),
    .rd_en_i       (out_ready),
    .rd_data_o     (d_out),
    .valid_o       (out_valid),
    .almost_full_o (almost_full),
    .wr_ok_o       (fifo_wr_ok),
    .drop_o        (fifo_drop)
  );

  assign sat        = sat_q;
  assign overflow   = overflow_q;
  assign frame_done = frame_done_q;

endmodule
